// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/response handshakes for the fetch and data ports plus
// the single-port block memory signals shared by mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
        input  mem_read_data,
        output i_req_ready, i_resp_valid, i_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_address, mem_write_enable, mem_write_data
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
        output mem_read_data,
        input  i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_address, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Zero-fills a single-port block memory after reset, then round-robin
// arbitrates one fetch or data access per cycle onto it.
module mem_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} owner_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_r;
    state_t            state_s;
    owner_t            owner_r;
    logic [ADDR_W-1:0] init_cnt_r;
    logic              last_d_r;
    logic              init_done_r;
    logic              grant_i_s;
    logic              grant_d_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Next state, round-robin grant and memory drive
    always_comb begin
        state_s     = state_r;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_we_s    = 1'b0;
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            ST_INIT: begin
                mem_we_s   = 1'b1;
                mem_addr_s = init_cnt_r;
                if (init_cnt_r == LAST_ADDR) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                // On a tie the port that did not win most recently goes first
                if (bus.i_req_valid && bus.d_req_valid) begin
                    grant_i_s = last_d_r;
                    grant_d_s = ~last_d_r;
                end else begin
                    grant_i_s = bus.i_req_valid;
                    grant_d_s = bus.d_req_valid;
                end
                if (grant_d_s) begin
                    mem_addr_s  = bus.d_req_addr;
                    mem_we_s    = bus.d_req_we;
                    mem_wdata_s = bus.d_req_wdata;
                end else if (grant_i_s) begin
                    mem_addr_s  = bus.i_req_addr;
                    mem_wdata_s = bus.d_req_wdata;
                end else begin
                    mem_addr_s  = {ADDR_W{1'b0}};
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Control state: FSM, fill counter, arbitration pointer, response owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= {ADDR_W{1'b0}};
            last_d_r    <= 1'b0;
            owner_r     <= OWN_NONE;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_done_r <= (state_s == ST_RUN);
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (grant_d_s) begin
                last_d_r <= 1'b1;
                owner_r  <= OWN_D;
            end else if (grant_i_s) begin
                last_d_r <= 1'b0;
                owner_r  <= OWN_I;
            end else begin
                owner_r  <= OWN_NONE;
            end
        end
    end

    // Memory drive is forced idle while reset is held so no fill write
    // happens before the first edge after release.
    assign bus.mem_write_enable = mem_we_s & rst_n;
    assign bus.mem_address      = rst_n ? mem_addr_s : {ADDR_W{1'b0}};
    assign bus.mem_write_data   = rst_n ? mem_wdata_s : {DATA_W{1'b0}};

    assign bus.i_req_ready  = grant_i_s;
    assign bus.d_req_ready  = grant_d_s;
    assign bus.i_resp_valid = (owner_r == OWN_I);
    assign bus.d_resp_valid = (owner_r == OWN_D);
    assign bus.i_resp_data  = (owner_r == OWN_I) ? bus.mem_read_data : {DATA_W{1'b0}};
    assign bus.d_resp_data  = (owner_r == OWN_D) ? bus.mem_read_data : {DATA_W{1'b0}};
    assign init_done        = init_done_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, a reference
// memory image and per-port response queues checked every cycle.
module tb_mem_port_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .bus       (bus)
    );

    // Single-port memory, registered read, read-before-write
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        bus.mem_read_data <= ram[bus.mem_address];
        if (bus.mem_write_enable) ram[bus.mem_address] <= bus.mem_write_data;
    end

    // Reference image and expected-response queues
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] iq [$];
    logic [DW-1:0] dq [$];

    always @(negedge clk) begin
        logic          ev;
        logic [DW-1:0] ed;
        if (!rst_n) begin
            iq.delete();
            dq.delete();
            for (int k = 0; k < DEPTH; k++) mdl[k] = 32'h0000_0000;
        end else begin
            ev = (iq.size() != 0);
            ed = ev ? iq.pop_front() : 32'h0000_0000;
            checks++;
            if (bus.i_resp_valid !== ev || bus.i_resp_data !== ed) begin
                failures++;
                $display("FAIL sb_i_resp got v=%b d=%h exp v=%b d=%h", bus.i_resp_valid, bus.i_resp_data, ev, ed);
            end
            ev = (dq.size() != 0);
            ed = ev ? dq.pop_front() : 32'h0000_0000;
            checks++;
            if (bus.d_resp_valid !== ev || bus.d_resp_data !== ed) begin
                failures++;
                $display("FAIL sb_d_resp got v=%b d=%h exp v=%b d=%h", bus.d_resp_valid, bus.d_resp_data, ev, ed);
            end
        end
        #2;
        if (rst_n) begin
            checks++;
            if (bus.i_req_ready === 1'b1 && bus.d_req_ready === 1'b1) begin
                failures++;
                $display("FAIL ready_exclusive got i=1 d=1 exp at most one");
            end
            if (bus.i_req_valid && bus.i_req_ready === 1'b1) iq.push_back(mdl[bus.i_req_addr]);
            if (bus.d_req_valid && bus.d_req_ready === 1'b1) begin
                dq.push_back(mdl[bus.d_req_addr]);
                if (bus.d_req_we) mdl[bus.d_req_addr] = bus.d_req_wdata;
            end
        end
    end

    task automatic drive(input logic iv, input logic [AW-1:0] ia, input logic dv,
                         input logic [AW-1:0] da, input logic we, input logic [DW-1:0] wd);
        @(negedge clk);
        bus.i_req_valid = iv;
        bus.i_req_addr  = ia;
        bus.d_req_valid = dv;
        bus.d_req_addr  = da;
        bus.d_req_we    = we;
        bus.d_req_wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 32'h0000_1234);
        checks++;
        if (init_done !== 1'b0 || bus.i_req_ready !== 1'b0 || bus.d_req_ready !== 1'b0 ||
            bus.i_resp_valid !== 1'b0 || bus.d_resp_valid !== 1'b0 ||
            bus.i_resp_data !== 32'h0 || bus.d_resp_data !== 32'h0 ||
            bus.mem_write_enable !== 1'b0 || bus.mem_address !== 5'd0 || bus.mem_write_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got done=%b rdy=%b%b rv=%b%b we=%b a=%h wd=%h exp all 0",
                     init_done, bus.i_req_ready, bus.d_req_ready, bus.i_resp_valid, bus.d_resp_valid,
                     bus.mem_write_enable, bus.mem_address, bus.mem_write_data);
        end
        #2 rst_n = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (bus.mem_write_enable !== 1'b1 || bus.mem_address !== 5'(k) || bus.mem_write_data !== 32'h0 ||
                init_done !== 1'b0 || bus.i_req_ready !== 1'b0 || bus.d_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL zero_fill k=%0d got we=%b a=%0d wd=%h done=%b rdy=%b%b exp we=1 a=%0d wd=0 done=0 rdy=00",
                         k, bus.mem_write_enable, bus.mem_address, bus.mem_write_data, init_done,
                         bus.i_req_ready, bus.d_req_ready, k);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (init_done !== 1'b1 || bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL init_done_first_tie got done=%b i=%b d=%b exp done=1 i=0 d=1",
                     init_done, bus.i_req_ready, bus.d_req_ready);
        end
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
    endtask

    task automatic test_write_read();
        drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0 || bus.mem_write_enable !== 1'b1 ||
            bus.mem_address !== 5'd5 || bus.mem_write_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_drive got rdy=%b%b we=%b a=%0d wd=%h exp rdy=01 we=1 a=5 wd=deadbeef",
                     bus.i_req_ready, bus.d_req_ready, bus.mem_write_enable, bus.mem_address, bus.mem_write_data);
        end
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (bus.i_req_ready !== 1'b1 || bus.mem_write_enable !== 1'b0 || bus.mem_address !== 5'd5 ||
            bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL write_ack got irdy=%b we=%b a=%0d dv=%b dd=%h exp irdy=1 we=0 a=5 dv=1 dd=0",
                     bus.i_req_ready, bus.mem_write_enable, bus.mem_address, bus.d_resp_valid, bus.d_resp_data);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (bus.i_resp_valid !== 1'b1 || bus.i_resp_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL read_after_write got v=%b d=%h exp v=1 d=deadbeef", bus.i_resp_valid, bus.i_resp_data);
        end
    endtask

    task automatic test_only_i();
        for (int a = 0; a < 4; a++) drive(1'b0, 5'd0, 1'b1, 5'(a), 1'b1, 32'h10 + 32'(a));
        for (int a = 0; a < 4; a++) begin
            drive(1'b1, 5'(a), 1'b0, 5'd0, 1'b0, 32'h0);
            checks++;
            if (bus.i_req_ready !== 1'b1) begin
                failures++;
                $display("FAIL only_i_ready a=%0d got %b exp 1", a, bus.i_req_ready);
            end
        end
        drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 32'h0);
        checks++;
        if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0 || bus.i_resp_data !== 32'h13) begin
            failures++;
            $display("FAIL tie_after_i got i=%b d=%b idata=%h exp i=0 d=1 idata=13",
                     bus.i_req_ready, bus.d_req_ready, bus.i_resp_data);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ia = 5'd16;
        logic [AW-1:0] da = 5'd20;
        logic          exp_i;
        for (int a = 16; a < 24; a++) drive(1'b0, 5'd0, 1'b1, 5'(a), 1'b1, 32'h100 + 32'(a));
        for (int k = 0; k < 8; k++) begin
            exp_i = (k % 2 == 0);
            drive(1'b1, ia, 1'b1, da, 1'b0, 32'h0);
            checks++;
            if (bus.i_req_ready !== exp_i || bus.d_req_ready !== !exp_i) begin
                failures++;
                $display("FAIL alternate k=%0d got i=%b d=%b exp i=%b d=%b",
                         k, bus.i_req_ready, bus.d_req_ready, exp_i, !exp_i);
            end
            if (exp_i) ia = ia + 5'd1;
            else       da = da + 5'd1;
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.d_resp_valid !== 1'b0 || bus.d_resp_data !== 32'h0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop got dv=%b dd=%h done=%b exp 0 0 0", bus.d_resp_valid, bus.d_resp_data, init_done);
        end
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (bus.mem_write_enable !== 1'b1 || bus.mem_address !== 5'(k) || init_done !== 1'b0) begin
                failures++;
                $display("FAIL refill k=%0d got we=%b a=%0d done=%b exp we=1 a=%0d done=0",
                         k, bus.mem_write_enable, bus.mem_address, init_done, k);
            end
            @(negedge clk);
            #1;
        end
        drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (init_done !== 1'b1 || bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL refill_readback got done=%b v=%b d=%h exp done=1 v=1 d=0",
                     init_done, bus.d_resp_valid, bus.d_resp_data);
        end
    endtask

    task automatic test_last_word();
        drive(1'b0, 5'd0, 1'b1, 5'd31, 1'b1, 32'hA5A5_A5A5);
        drive(1'b1, 5'd0, 1'b1, 5'd31, 1'b0, 32'h0);
        checks++;
        if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL tie_after_d got i=%b d=%b exp i=1 d=0", bus.i_req_ready, bus.d_req_ready);
        end
        drive(1'b0, 5'd0, 1'b1, 5'd31, 1'b0, 32'h0);
        checks++;
        if (bus.d_req_ready !== 1'b1 || bus.i_resp_valid !== 1'b1 || bus.i_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL addr0_read got drdy=%b iv=%b id=%h exp 1 1 0",
                     bus.d_req_ready, bus.i_resp_valid, bus.i_resp_data);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL last_word got v=%b d=%h exp v=1 d=a5a5a5a5", bus.d_resp_valid, bus.d_resp_data);
        end
    endtask

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = 5'd0;
        bus.d_req_valid = 1'b0;
        bus.d_req_addr  = 5'd0;
        bus.d_req_we    = 1'b0;
        bus.d_req_wdata = 32'h0;
        test_reset();
        test_write_read();
        test_only_i();
        test_back_to_back();
        test_reset_mid();
        test_last_word();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Controller and two-way arbiter sharing the single-port, one-cycle-read-latency block memory between the instruction-fetch port (read-only) and the data port (read/write) of the core. After reset it sequences a zero-fill of the whole memory and then grants one access per cycle using round-robin arbitration. Read data is routed back to the winning requester one cycle after acceptance.

## Interface
- ADDR_W, 5: memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32: data word width.

- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- INIT_DONE  out  1  high once zero-fill complete
- I_REQ_VALID  in  1  fetch request
- I_REQ_READY  out  1  fetch request accepted this cycle
- I_REQ_ADDR  in  ADDR_W  fetch address
- I_RESP_VALID  out  1  fetch data valid
- I_RESP_DATA  out  DATA_W  fetch data
- D_REQ_VALID  in  1  data request
- D_REQ_READY  out  1  data request accepted this cycle
- D_REQ_ADDR  in  ADDR_W  data address
- D_REQ_WE  in  1  1 = write, 0 = read
- D_REQ_WDATA  in  DATA_W  write data
- D_RESP_VALID  out  1  data response (read data or write ack)
- D_RESP_DATA  out  DATA_W  read data; pre-write contents on write ack
- MEM_ADDRESS  out  ADDR_W  to memory ADDRESS
- MEM_WRITE_ENABLE  out  1  to memory WRITE_ENABLE
- MEM_WRITE_DATA  out  DATA_W  to memory WRITE_DATA
- MEM_READ_DATA  in  DATA_W  from memory READ_DATA (registered in memory, 1-cycle latency, read-before-write)

## Operation
- States: INIT, RUN. Reset → INIT, init counter = 0.
- INIT: MEM_WRITE_ENABLE=1, MEM_ADDRESS=counter, MEM_WRITE_DATA=0; counter increments each cycle; after writing DEPTH-1 → RUN. I/D_REQ_READY=0 throughout INIT.
- RUN: INIT_DONE=1 (registered). Never returns to INIT except via reset.
- Grant (RUN only, combinational from VALIDs and pointer):
  - only I valid → grant I; only D valid → grant D.
  - both valid → grant the port not granted most recently (pointer `last`).
  - `last` updates to the granted port on every grant; holds when idle. Reset value of `last` = I, so first tie goes to D.
- Exactly one READY high per cycle at most; READY = grant, asserted combinationally in the same cycle as VALID (no wait states in RUN).
- Memory drive in RUN: granted port's address; MEM_WRITE_ENABLE = grant_D & D_REQ_WE; MEM_WRITE_DATA = D_REQ_WDATA. No grant → MEM_WRITE_ENABLE=0, MEM_ADDRESS=0, MEM_WRITE_DATA=0.
- Response tracking: registered owner flag {none, I, D} captured on accept; X_RESP_VALID = owner==X (registered). X_RESP_DATA = MEM_READ_DATA when owner==X, else 0.
- Responses are unconditionally consumed; no back-pressure on responses.
- Addresses are ADDR_W bits; no range check, no wrap logic beyond natural width.

## Timing
- Reset values (RSTN low, asynchronously): INIT_DONE=0, I/D_REQ_READY=0, I/D_RESP_VALID=0, I/D_RESP_DATA=0, MEM_WRITE_ENABLE=0, MEM_ADDRESS=0, MEM_WRITE_DATA=0, state=INIT, counter=0, owner=none, last=I.
- Init: first zero write on first rising edge after RSTN deasserts; DEPTH cycles total; INIT_DONE rises on edge DEPTH; first request acceptable in that cycle.
- Latency: request accepted in cycle t (VALID & READY at edge t) → RESP_VALID high for exactly one cycle t+1 with data.
- Throughput: one access per cycle; back-to-back accepts on either port or alternating ports with no bubble.
- Write then read same address in consecutive cycles: read returns new data (write committed at edge t).
- Write response: D_RESP_VALID in t+1 with old contents.
- Reset mid-operation: pending response dropped (RESP_VALID falls immediately), pointer reset, zero-fill restarts from address 0.
- A requester holding VALID while not granted must keep ADDR/WE/WDATA stable; arbiter does not latch them.

## Test plan
- Reset release: INIT_DONE=0 for 32 cycles, READY=0 with VALID held; MEM writes 0 to addresses 0..31 in order; INIT_DONE=1 at cycle 32.
- D write 0xDEADBEEF to addr 5 at cycle t, I read addr 5 at t+1 → D_RESP_VALID at t+1 with 0x00000000, I_RESP_VALID at t+2 with 0xDEADBEEF.
- Both VALID continuously after init, distinct addresses pre-written → grants D, I, D, I…; each RESP_VALID one cycle after its grant, never both in same cycle.
- Only I VALID for 4 cycles, addrs 0..3 pre-written 0x10..0x13 → READY every cycle, I_RESP_DATA 0x10..0x13 in cycles t+1..t+4; then tie → D wins.
- RSTN low one cycle after a D read accept → D_RESP_VALID stays 0, INIT_DONE=0, zero-fill restarts at addr 0; previously written data reads back 0 after init.
- Last word: write 0xA5A5A5A5 to addr 31, read addr 31 → 0xA5A5A5A5; read addr 0 → 0.
